// File: rtl/cpu_dp_pkg.sv
// Shared encodings for the parametrised CPU datapath: bus sources, ALU ops,
// memory-handshake states and width helpers.
package cpu_dp_pkg;

  localparam int BUS_SRC_W = 3;
  localparam int ALU_OP_W  = 4;

  typedef enum logic [BUS_SRC_W-1:0] {
    BUS_ZERO = 3'd0,
    BUS_PC   = 3'd1,
    BUS_MEM  = 3'd2,
    BUS_DR   = 3'd3,
    BUS_DRTR = 3'd4,
    BUS_REG  = 3'd5,
    BUS_AC   = 3'd6,
    BUS_TR   = 3'd7
  } bus_src_e;

  // Codes 11..15 are reserved and leave AC and the flags untouched.
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOT  = 4'd6,
    ALU_INC  = 4'd7,
    ALU_ZERO = 4'd8,
    ALU_SHL  = 4'd9,
    ALU_SHR  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } mem_state_e;

  function automatic int rsel_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/cpu_datapath_param_alu.sv
// Combinational ALU: A op B with carry/borrow/shift-out; op_valid low for
// reserved opcodes so the caller can suppress AC and flag writes.
module cpu_alu
  import cpu_dp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  output logic [W-1:0]        result,
  output logic                carry,
  output logic                op_valid
);

  logic [W:0] wide;

  always_comb begin
    wide     = '0;
    result   = '0;
    carry    = 1'b0;
    op_valid = 1'b1;
    case (op)
      ALU_PASS: result = b;
      ALU_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[W-1:0];
        carry  = wide[W];
      end
      // The extra top bit of the difference is the borrow.
      ALU_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[W-1:0];
        carry  = wide[W];
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOT:  result = ~a;
      ALU_INC: begin
        wide   = {1'b0, a} + (W+1)'(1);
        result = wide[W-1:0];
        carry  = wide[W];
      end
      ALU_ZERO: result = '0;
      ALU_SHL: begin
        result = {a[W-2:0], 1'b0};
        carry  = a[W-1];
      end
      ALU_SHR: begin
        result = {1'b0, a[W-1:1]};
        carry  = a[0];
      end
      default: op_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_datapath_param.sv
// CPU datapath: AR/PC/DR/IR/TR/AC, flags and register file around a muxed bus,
// with a req/ack memory handshake that stalls micro-op execution via busy.
module cpu_datapath_param
  import cpu_dp_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 16,
  parameter int                NREG     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int               RSEL_W   = rsel_width(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [BUS_SRC_W-1:0] bus_src,
  input  logic                 ar_ld,
  input  logic                 ar_inc,
  input  logic                 pc_ld,
  input  logic                 pc_inc,
  input  logic                 dr_ld,
  input  logic                 ir_ld,
  input  logic                 tr_ld,
  input  logic                 r_ld,
  input  logic                 ac_ld,
  input  logic                 ac_ldr,
  input  logic                 z_ld,
  input  logic [RSEL_W-1:0]    r_sel,
  input  logic [ALU_OP_W-1:0]  alus,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ack,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    ac_q,
  output logic [DATA_W-1:0]    r_q,
  output logic [DATA_W-1:0]    ir_q,
  output logic                 z,
  output logic                 c,
  output logic                 busy,
  output logic                 err
);

  logic [ADDR_W-1:0]   ar_reg, pc_reg, bus;
  logic [DATA_W-1:0]   dr_reg, ir_reg, tr_reg, ac_reg, wdata_reg, bus_d;
  logic [DATA_W-1:0]   r_reg [NREG];
  logic [2*DATA_W-1:0] dr_tr;
  logic [NREG-1:0]     r_we;
  logic                z_reg, c_reg, err_reg, req_reg, we_reg, req_next, we_next;
  logic                step, alu_c, alu_ok;
  logic [DATA_W-1:0]   alu_res;
  mem_state_e          state_reg, state_next;

  assign busy  = (state_reg != ST_IDLE);
  assign step  = en && !busy;
  assign dr_tr = {dr_reg, tr_reg};
  assign bus_d = bus[DATA_W-1:0];

  always_comb begin
    bus = '0;
    case (bus_src)
      BUS_PC:   bus = pc_reg;
      BUS_MEM:  bus = ADDR_W'(mem_rdata);
      BUS_DR:   bus = ADDR_W'(dr_reg);
      BUS_DRTR: bus = dr_tr[ADDR_W-1:0];
      BUS_REG:  bus = ADDR_W'(r_reg[r_sel]);
      BUS_AC:   bus = ADDR_W'(ac_reg);
      BUS_TR:   bus = ADDR_W'(tr_reg);
      default:  bus = '0;
    endcase
  end

  cpu_alu #(.W(DATA_W)) u_alu (
    .op       (alus),
    .a        (ac_reg),
    .b        (bus_d),
    .result   (alu_res),
    .carry    (alu_c),
    .op_valid (alu_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_reg    <= '0;
      pc_reg    <= RESET_PC;
      dr_reg    <= '0;
      ir_reg    <= '0;
      tr_reg    <= '0;
      ac_reg    <= '0;
      z_reg     <= 1'b0;
      c_reg     <= 1'b0;
      wdata_reg <= '0;
    end else if (step) begin
      if (ar_ld)       ar_reg <= bus;
      else if (ar_inc) ar_reg <= ar_reg + ADDR_W'(1);
      if (pc_ld)       pc_reg <= bus;
      else if (pc_inc) pc_reg <= pc_reg + ADDR_W'(1);
      if (ir_ld)       ir_reg <= dr_reg;
      if (tr_ld)       tr_reg <= dr_reg;
      if (dr_ld)       dr_reg <= bus_d;
      // ac_ld claims AC even for reserved ops, which then leave it unchanged.
      if (ac_ld) begin
        if (alu_ok) ac_reg <= alu_res;
      end else if (ac_ldr) begin
        ac_reg <= bus_d;
      end
      if (z_ld && alu_ok) begin
        z_reg <= (alu_res == '0);
        c_reg <= alu_c;
      end
      if (mem_wr && !mem_rd) wdata_reg <= bus_d;
    end else if (state_reg == ST_RD_WAIT && mem_ack) begin
      dr_reg <= mem_rdata;
    end
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_rwe
    assign r_we[gi] = step && r_ld && (r_sel == RSEL_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (r_we[i]) r_reg[i] <= bus_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (step && mem_rd && !mem_wr)      state_next = ST_RD_WAIT;
        else if (step && mem_wr && !mem_rd) state_next = ST_WR_WAIT;
      end
      ST_RD_WAIT, ST_WR_WAIT: if (mem_ack) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they change with it.
  always_comb begin
    req_next = (state_next != ST_IDLE);
    we_next  = (state_next == ST_WR_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if ((step && mem_rd && mem_wr) || (busy && (mem_rd || mem_wr))) begin
      err_reg <= 1'b1;
    end
  end

  assign mem_addr  = ar_reg;
  assign mem_wdata = wdata_reg;
  assign mem_req   = req_reg;
  assign mem_we    = we_reg;
  assign ac_q      = ac_reg;
  assign r_q       = r_reg[r_sel];
  assign ir_q      = ir_reg;
  assign z         = z_reg;
  assign c         = c_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_cpu_datapath_param.sv
// Self-checking bench for cpu_datapath_param: an integer-arithmetic model of the
// architectural state is compared every cycle, plus hand-computed directed checks.
module tb_cpu_datapath_param;

  localparam int          NR  = 4;
  localparam logic [15:0] RPC = 16'h0100;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [2:0]  bus_src = '0;
  logic        ar_ld = 0, ar_inc = 0, pc_ld = 0, pc_inc = 0, dr_ld = 0, ir_ld = 0;
  logic        tr_ld = 0, r_ld = 0, ac_ld = 0, ac_ldr = 0, z_ld = 0;
  logic [1:0]  r_sel = '0;
  logic [3:0]  alus = '0;
  logic        mem_rd = 0, mem_wr = 0, mem_ack = 0;
  logic [7:0]  mem_rdata = '0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, ac_q, r_q, ir_q;
  logic        mem_req, mem_we, z, c, busy, err;

  cpu_datapath_param #(.DATA_W(8), .ADDR_W(16), .NREG(NR), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .en(en), .bus_src(bus_src),
    .ar_ld(ar_ld), .ar_inc(ar_inc), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .dr_ld(dr_ld), .ir_ld(ir_ld), .tr_ld(tr_ld), .r_ld(r_ld),
    .ac_ld(ac_ld), .ac_ldr(ac_ldr), .z_ld(z_ld), .r_sel(r_sel), .alus(alus),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .ac_q(ac_q), .r_q(r_q), .ir_q(ir_q), .z(z), .c(c), .busy(busy), .err(err)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit run_cmp = 0;

  // Architectural model: pend 0 = none, 1 = read outstanding, 2 = write outstanding.
  int m_ar, m_pc, m_dr, m_ir, m_tr, m_ac, m_wdata, m_pend;
  int m_r[NR];
  bit m_z, m_c, m_err;

  int tv_op[11] = '{3, 4, 5, 6, 7, 8, 9, 12, 10, 0, 2};
  int tv_ac[11] = '{'h14, 'hBE, 'hAA, 'h69, 'h97, 'h00, 'h2C, 'h96, 'h4B, 'h3C, 'h5A};
  int tv_c[11]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ar = 0; m_pc = int'(RPC); m_dr = 0; m_ir = 0; m_tr = 0; m_ac = 0;
    m_wdata = 0; m_pend = 0; m_z = 0; m_c = 0; m_err = 0;
    for (int i = 0; i < NR; i++) m_r[i] = 0;
  endtask

  task automatic model_step();
    int b, bd, res, cy;
    bit ok;
    if (m_pend != 0) begin
      if (mem_rd || mem_wr) m_err = 1;
      if (mem_ack) begin
        if (m_pend == 1) m_dr = int'(mem_rdata);
        m_pend = 0;
      end
      return;
    end
    if (!en) return;
    case (int'(bus_src))
      1: b = m_pc;
      2: b = int'(mem_rdata);
      3: b = m_dr;
      4: b = m_dr * 256 + m_tr;
      5: b = m_r[r_sel];
      6: b = m_ac;
      7: b = m_tr;
      default: b = 0;
    endcase
    bd = b % 256;
    ok = 1; cy = 0;
    case (int'(alus))
      0: res = bd;
      1: begin res = m_ac + bd; cy = (res > 255) ? 1 : 0; end
      2: begin res = m_ac - bd; cy = (res < 0) ? 1 : 0; end
      3: res = m_ac & bd;
      4: res = m_ac | bd;
      5: res = m_ac ^ bd;
      6: res = 255 - m_ac;
      7: begin res = m_ac + 1; cy = (res > 255) ? 1 : 0; end
      8: res = 0;
      9: begin res = m_ac * 2; cy = m_ac / 128; end
      10: begin res = m_ac / 2; cy = m_ac % 2; end
      default: begin res = 0; ok = 0; end
    endcase
    res = res & 255;
    if (ir_ld) m_ir = m_dr;
    if (tr_ld) m_tr = m_dr;
    if (dr_ld) m_dr = bd;
    if (r_ld) m_r[r_sel] = bd;
    if (ac_ld) begin
      if (ok) m_ac = res;
    end else if (ac_ldr) m_ac = bd;
    if (z_ld && ok) begin m_z = (res == 0); m_c = cy[0]; end
    if (pc_ld) m_pc = b; else if (pc_inc) m_pc = (m_pc + 1) % 65536;
    if (ar_ld) m_ar = b; else if (ar_inc) m_ar = (m_ar + 1) % 65536;
    if (mem_rd && mem_wr) m_err = 1;
    else if (mem_rd) m_pend = 1;
    else if (mem_wr) begin m_pend = 2; m_wdata = bd; end
  endtask

  initial forever begin
    @(negedge clk);
    if (run_cmp) begin
      check("cyc_mem_addr", 32'(mem_addr), m_ar);
      check("cyc_mem_wdata", 32'(mem_wdata), m_wdata);
      check("cyc_mem_req", 32'(mem_req), (m_pend != 0) ? 1 : 0);
      check("cyc_mem_we", 32'(mem_we), (m_pend == 2) ? 1 : 0);
      check("cyc_busy", 32'(busy), (m_pend != 0) ? 1 : 0);
      check("cyc_ac", 32'(ac_q), m_ac);
      check("cyc_r_q", 32'(r_q), m_r[r_sel]);
      check("cyc_ir", 32'(ir_q), m_ir);
      check("cyc_z", 32'(z), 32'(m_z));
      check("cyc_c", 32'(c), 32'(m_c));
      check("cyc_err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic ctl_clear();
    en = 1; bus_src = 0; ar_ld = 0; ar_inc = 0; pc_ld = 0; pc_inc = 0;
    dr_ld = 0; ir_ld = 0; tr_ld = 0; r_ld = 0; ac_ld = 0; ac_ldr = 0; z_ld = 0;
    r_sel = 0; alus = 0; mem_rd = 0; mem_wr = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  // Asserts reset between edges and checks the outputs drop before any edge.
  task automatic do_reset();
    #2;
    rst = 1;
    model_reset();
    #1;
    check("async_mem_req", 32'(mem_req), 0);
    check("async_busy", 32'(busy), 0);
    check("async_err", 32'(err), 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    model_reset();
    run_cmp = 1;
    @(negedge clk);
    #1;
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_ac", 32'(ac_q), 0);
    rst = 0;
    ctl_clear();

    bus_src = 1; ar_ld = 1; tick();
    check("reset_pc", 32'(mem_addr), 32'h0100);
    ctl_clear(); pc_inc = 1; tick();
    ctl_clear(); bus_src = 1; ar_ld = 1; tick();
    check("pc_inc", 32'(mem_addr), 32'h0101);

    ctl_clear(); bus_src = 2; mem_rdata = 8'h05; r_sel = 2; r_ld = 1; tick();
    ctl_clear(); bus_src = 2; mem_rdata = 8'hFF; ac_ldr = 1; tick();
    ctl_clear(); bus_src = 5; r_sel = 2; alus = 1; ac_ld = 1; z_ld = 1; tick();
    check("add_r_q", 32'(r_q), 32'h05);
    check("add_ac", 32'(ac_q), 32'h04);
    check("add_c", 32'(c), 1);
    check("add_z", 32'(z), 0);
    ctl_clear(); bus_src = 6; alus = 2; ac_ld = 1; z_ld = 1; tick();
    check("sub_ac", 32'(ac_q), 32'h00);
    check("sub_z", 32'(z), 1);
    check("sub_c", 32'(c), 0);

    for (int i = 0; i < 11; i++) begin
      ctl_clear(); bus_src = 2; mem_rdata = 8'h96; ac_ldr = 1; tick();
      ctl_clear(); bus_src = 2; mem_rdata = 8'h3C; alus = 4'(tv_op[i]);
      ac_ld = 1; z_ld = 1; tick();
      check($sformatf("alu_op%0d_ac", tv_op[i]), 32'(ac_q), tv_ac[i]);
      check($sformatf("alu_op%0d_c", tv_op[i]), 32'(c), tv_c[i]);
      check($sformatf("alu_op%0d_z", tv_op[i]), 32'(z), (tv_ac[i] == 0) ? 1 : 0);
    end

    ctl_clear(); bus_src = 2; mem_rdata = 8'h34; dr_ld = 1; tick();
    ctl_clear(); tr_ld = 1; ir_ld = 1; tick();
    check("ir_from_dr", 32'(ir_q), 32'h34);
    ctl_clear(); bus_src = 2; mem_rdata = 8'h12; dr_ld = 1; tick();
    ctl_clear(); bus_src = 4; pc_ld = 1; pc_inc = 1; tick();
    ctl_clear(); bus_src = 1; ar_ld = 1; tick();
    check("pc_ld_wins", 32'(mem_addr), 32'h1234);
    ctl_clear(); bus_src = 2; mem_rdata = 8'hFF; dr_ld = 1; tick();
    ctl_clear(); tr_ld = 1; tick();
    ctl_clear(); bus_src = 4; ar_ld = 1; ar_inc = 1; tick();
    check("ar_ffff", 32'(mem_addr), 32'hFFFF);
    ctl_clear(); ar_inc = 1; tick();
    check("ar_wrap", 32'(mem_addr), 32'h0000);

    // Read with three wait cycles; loads attempted while busy must be ignored.
    ctl_clear(); bus_src = 2; mem_rdata = 8'h5A; ac_ldr = 1; tick();
    ctl_clear(); mem_rd = 1; tick();
    check("rd_req", 32'(mem_req), 1);
    check("rd_we", 32'(mem_we), 0);
    ctl_clear(); bus_src = 2; mem_rdata = 8'h77; ac_ldr = 1; dr_ld = 1; ar_ld = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rd_busy_wait%0d", k), 32'(busy), 1);
    end
    mem_ack = 1; mem_rdata = 8'hA5; tick();
    ctl_clear();
    check("rd_done_busy", 32'(busy), 0);
    check("rd_done_req", 32'(mem_req), 0);
    check("rd_ac_untouched", 32'(ac_q), 32'h5A);
    check("rd_ar_untouched", 32'(mem_addr), 32'h0000);
    bus_src = 3; ac_ldr = 1; tick();
    check("rd_dr", 32'(ac_q), 32'hA5);

    // Write, with en dropped while waiting for ack.
    ctl_clear(); bus_src = 2; mem_rdata = 8'h3C; ac_ldr = 1; tick();
    ctl_clear(); bus_src = 6; mem_wr = 1; tick();
    check("wr_we", 32'(mem_we), 1);
    check("wr_req", 32'(mem_req), 1);
    check("wr_wdata", 32'(mem_wdata), 32'h3C);
    ctl_clear(); en = 0; bus_src = 2; mem_rdata = 8'hC3; tick(); tick();
    check("wr_wdata_hold", 32'(mem_wdata), 32'h3C);
    check("wr_we_hold", 32'(mem_we), 1);
    mem_ack = 1; tick();
    ctl_clear();
    check("wr_done_req", 32'(mem_req), 0);
    check("wr_done_we", 32'(mem_we), 0);

    // Protocol errors.
    do_reset();
    ctl_clear(); mem_rd = 1; mem_wr = 1; tick();
    check("both_req", 32'(mem_req), 0);
    check("both_err", 32'(err), 1);
    do_reset();
    ctl_clear(); mem_rd = 1; tick();
    ctl_clear(); mem_rd = 1; tick();
    check("busy_rd_err", 32'(err), 1);
    check("busy_rd_busy", 32'(busy), 1);
    ctl_clear(); mem_ack = 1; mem_rdata = 8'h5A; tick();
    ctl_clear();
    check("busy_rd_done", 32'(busy), 0);
    bus_src = 3; ac_ldr = 1; tick();
    check("busy_rd_dr", 32'(ac_q), 32'h5A);

    // Reset in the middle of a read with ack pending: DR must not load.
    ctl_clear(); mem_rd = 1; tick();
    ctl_clear(); mem_ack = 1; mem_rdata = 8'hEE;
    do_reset();
    ctl_clear(); bus_src = 3; ac_ldr = 1; tick();
    check("rst_mid_dr", 32'(ac_q), 32'h00);
    check("rst_mid_busy", 32'(busy), 0);

    run_cmp = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_datapath_param.md
# cpu_datapath_param

Parametrised successor to the CPU dataflow block: holds AR, PC, DR, IR, TR, AC, Z/C flags and an NREG-entry general register file around a multiplexed (non-tristate) internal bus. Executes the controller's per-cycle micro-operations. Talks to memory through a req/ack handshake with wait states and stalls the controller via `busy`. It sits between the controller and the memory/IO wrapper.

## Interface
- DATA_W, 8: data/register width
- ADDR_W, 16: address width; constraint DATA_W <= ADDR_W <= 2*DATA_W
- NREG, 4: general registers (>= 2); RSEL_W = $clog2(NREG)
- RESET_PC, 0: PC value after reset
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable from start/stop circuit; 0 freezes micro-ops
- bus_src  in  3  bus driver: 0 none (zero), 1 PC, 2 MEMDATA, 3 DR, 4 {DR,TR}, 5 R[r_sel], 6 AC, 7 TR
- ar_ld, ar_inc, pc_ld, pc_inc, dr_ld, ir_ld, tr_ld, r_ld, ac_ld, ac_ldr, z_ld  in  1 each  register controls
- r_sel  in  RSEL_W  register-file index for read and write
- alus  in  4  ALU op
- mem_rd, mem_wr  in  1  one-cycle memory request pulses
- mem_rdata  in  DATA_W  memory read data
- mem_ack  in  1  memory completion
- mem_addr  out  ADDR_W  = AR
- mem_wdata  out  DATA_W  registered write data
- mem_req  out  1  request active
- mem_we  out  1  1 = write transaction
- ac_q, r_q  out  DATA_W  AC, R[r_sel]
- ir_q  out  DATA_W  IR to controller
- z, c  out  1  flags
- busy  out  1  transaction in flight
- err  out  1  sticky protocol error

## Operation
- Bus: DATA_W sources zero-extend to ADDR_W; {DR,TR} is DR high, TR low, truncated to ADDR_W; MEMDATA = mem_rdata. Register data inputs take bus[DATA_W-1:0].
- Update on rising clk only when en=1 and busy=0 ("step"). Else all registers hold.
- Step priorities: pc_ld over pc_inc, ar_ld over ar_inc (wrap at 2^ADDR_W). ac_ld (ALU result) over ac_ldr (bus).
- IR and TR load from DR, not the bus.
- ALU operands: A=AC, B=bus. Ops: 0 pass B, 1 A+B, 2 A-B, 3 AND, 4 OR, 5 XOR, 6 NOT A, 7 A+1, 8 zero, 9 A<<1, 10 A>>1 (logical). 11-15 leave AC unchanged: AC is not written and z/c hold, even with ac_ld/z_ld.
- z_ld: z = (result==0); c = carry-out (ops 1,7), borrow (op 2), shifted-out bit (9,10), else 0.
- Memory FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE + step + mem_rd -> RD_WAIT.
  - IDLE + step + mem_wr -> WR_WAIT; mem_wdata <= bus.
  - Both asserted: no transaction; err set.
  - RD_WAIT + mem_ack: DR <= mem_rdata (dr_ld not needed) -> IDLE.
  - WR_WAIT + mem_ack -> IDLE.
- mem_req=1 in RD_WAIT/WR_WAIT; mem_we=1 in WR_WAIT. busy = state != IDLE.
- mem_rd/mem_wr during busy: ignored, err set. mem_ack in IDLE: ignored.
- FSM progress ignores en: a started transaction completes with en=0.

## Timing
- Reset (async): AR, DR, IR, TR, AC, all R = 0; PC = RESET_PC; z=c=0; FSM IDLE; mem_req=mem_we=0; mem_wdata=0; err=0. Release synchronous to next edge.
- Reset mid-transaction: mem_req drops immediately; DR is not loaded.
- Read: request edge T -> mem_req high from T+1. mem_ack sampled at edge T+k (k>=1) -> DR valid, busy low, mem_req low after T+k. Minimum 2 cycles; 0-wait write also 2.
- Outputs registered except r_q (comb read of R[r_sel]) and busy (decode of state register).

## Structure
- Package cpu_dp_pkg holds: bus_src codes, ALU op codes, FSM state enum, width-derived constants.
- Sub-module cpu_alu (combinational: op, A, B -> result, carry). Bus mux, registers and FSM stay in the top.

## Test plan
- Reset: hold rst mid-cycle -> PC=RESET_PC, all else 0, mem_req=0 asynchronously.
- Bus/ALU: R[2]=0x05, AC=0xFF; alus=1, bus_src=5, r_sel=2, ac_ld, z_ld -> AC=0x04, c=1, z=0; then alus=2 with B=0x04 -> AC=0x00, z=1, c=0.
- Address load: DR=0x12, TR=0x34; bus_src=4, pc_ld+pc_inc -> PC=0x1234 (load wins). ar_inc at AR=0xFFFF -> 0x0000.
- Read with 3 wait cycles: mem_rd at T; ack at T+4 with mem_rdata=0xA5 -> busy T+1..T+4, DR=0xA5 after T+4, loads requested during busy ignored.
- Write: AC=0x3C, bus_src=6, mem_wr -> mem_we=1, mem_wdata=0x3C held until ack; en dropped mid-wait still completes.
- Errors: mem_rd+mem_wr together -> no mem_req, err=1. mem_rd while busy -> err=1, current transaction unaffected.
